ascon_ctrl: RTL and testbench
=============================

ASCON_CTRL -- requirements
Module: ascon_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS_A, default 12, rounds for initialisation and finalisation permutation.
REQ-002 SHALL have parameter ROUNDS_B, default 6, rounds for intermediate permutation (ROUNDS_B <= ROUNDS_A).
REQ-003 SHALL have ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  level start request from control register.
- mode_i  in  4  bit0: 0 encrypt, 1 decrypt; bits 3:1 ignored.
- bdi_valid_i  in  1  input word valid.
- bdi_type_i  in  4  bits1:0 type (1 AD, 2 text, 3 tag); bit3 last word of this type.
- bdi_ready_o  out  1  controller accepts word.
- load_init_o  out  1  datapath loads IV||key||nonce into state.
- absorb_o  out  1  datapath XORs accepted word into state (text: also emits bdo).
- absorb_last_o  out  1  accepted word is last of its type; datapath pads.
- key_xor_o  out  1  XOR key into state (after init / before final).
- dsep_o  out  1  domain-separation XOR.
- round_en_o  out  1  apply one permutation round this cycle.
- round_idx_o  out  4  round-constant index.
- tag_out_o  out  1  datapath drives tag word tag_idx_o on bdo.
- tag_idx_o  out  2  tag word index 0..3.
- tag_eq_i  in  1  received tag word equals computed word.
- busy_o  out  1  operation in progress.
- done_o  out  1  operation complete.
- auth_o  out  1  decrypt tag matched.

Function
REQ-004 SHALL start only on rising edge of start_i (registered previous value) while in IDLE or DONE; edges while busy ignored; level held high does not restart.
REQ-005 SHALL latch mode_i[0] at start; later mode_i changes ignored until next start.
REQ-006 SHALL implement states IDLE, INIT, INIT_PERM, AD_ABS, AD_PERM, TXT_ABS, TXT_PERM, FIN_PERM, TAG, DONE.
REQ-007 INIT: one cycle, load_init_o=1, then INIT_PERM.
REQ-008 PERM states: round_en_o=1 every cycle, internal counter steps round_idx_o from 12-R to 11 (R=ROUNDS_A in INIT_PERM/FIN_PERM, ROUNDS_B in AD_PERM/TXT_PERM), exit in cycle after index 11 issued; permutation takes exactly R cycles.
REQ-009 After INIT_PERM: key_xor_o pulse one cycle on exit, go AD_ABS.
REQ-010 AD_ABS: bdi_ready_o=1; word counter (0..1, 2 words = 64-bit rate block); AD word accepted -> absorb_o=1; after second word or last-flagged word -> AD_PERM, counter cleared.
REQ-011 AD_PERM exit: if last AD absorbed -> dsep_o pulse, TXT_ABS; else AD_ABS.
REQ-012 Text word arriving in AD_ABS with counter 0 (empty AD / AD complete) -> dsep_o pulse, word NOT accepted that cycle (bdi_ready_o=0), TXT_ABS next.
REQ-013 TXT_ABS: text word accepted -> absorb_o=1; last-flagged word -> key_xor_o pulse next cycle, then FIN_PERM (no intermediate permutation); second non-last word -> TXT_PERM, then TXT_ABS.
REQ-014 Words of unexpected type accepted (ready=1) and dropped without absorb_o.
REQ-015 FIN_PERM exit: key_xor_o pulse, TAG, auth register set to 1.
REQ-016 TAG encrypt: tag_out_o=1 for 4 consecutive cycles, tag_idx_o 0,1,2,3, bdi_ready_o=0.
REQ-017 TAG decrypt: bdi_ready_o=1; each accepted tag word: tag_idx_o = index, auth <= auth & tag_eq_i; after index 3 -> DONE.
REQ-018 DONE: done_o=1, busy_o=0, auth_o valid (0 for encrypt), held until next start edge, which clears done_o and auth_o.
REQ-019 busy_o=1 in every state except IDLE and DONE.
REQ-020 Single-cycle strobes (load_init_o, key_xor_o, dsep_o, absorb_o) SHALL never assert simultaneously with round_en_o.

Reset
REQ-021 Asynchronous rst_ni low SHALL force IDLE, counters 0, start edge register 0, all outputs 0, aborting any operation immediately.
REQ-022 After reset release with start_i already high, no start occurs until start_i falls and rises.

Verification
REQ-023 Encrypt, 2 AD words (second last), 2 text words (second last): INIT 1 cycle, 12 round_en cycles idx 0..11, AD_PERM 6 cycles idx 6..11, dsep pulse, no TXT_PERM, FIN 12 cycles, tag_out 4 cycles, done_o=1, auth_o=0.
REQ-024 Decrypt, empty AD, 1 text word last, 4 tag words all tag_eq_i=1 -> dsep pulse before first text accept, done_o=1, auth_o=1; repeat with tag_eq_i=0 on word 2 -> auth_o=0.
REQ-025 Start rising edge during AD_ABS -> ignored, sequence unchanged; start held high after DONE -> no restart.
REQ-026 rst_ni asserted mid FIN_PERM -> all outputs 0 same cycle, IDLE after release.
REQ-027 bdi_valid_i with type 3 during AD_ABS -> accepted, no absorb_o, state unchanged; mode_i toggled mid-operation -> no effect.

Source files
------------

// File: rtl/ascon_ctrl.sv
// ascon_ctrl: sequencing FSM for an Ascon AEAD datapath. Walks the datapath
// through init, AD absorption, text absorption, finalisation and tag
// emission/check, issuing one-cycle strobes and per-round enables.
module ascon_ctrl #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [3:0] mode_i,
  input  logic       bdi_valid_i,
  input  logic [3:0] bdi_type_i,
  output logic       bdi_ready_o,
  output logic       load_init_o,
  output logic       absorb_o,
  output logic       absorb_last_o,
  output logic       key_xor_o,
  output logic       dsep_o,
  output logic       round_en_o,
  output logic [3:0] round_idx_o,
  output logic       tag_out_o,
  output logic [1:0] tag_idx_o,
  input  logic       tag_eq_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       auth_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_INIT_PERM, S_AD_ABS, S_AD_PERM,
    S_TXT_ABS, S_TXT_PERM, S_FIN_PERM, S_TAG, S_DONE
  } state_t;

  localparam logic [3:0] RND_A0   = 4'(12 - ROUNDS_A);
  localparam logic [3:0] RND_B0   = 4'(12 - ROUNDS_B);
  localparam logic [3:0] RND_LAST = 4'd11;
  localparam logic [1:0] T_AD     = 2'd1;
  localparam logic [1:0] T_TXT    = 2'd2;
  localparam logic [1:0] T_TAG    = 2'd3;

  state_t     state_reg, state_next;
  logic       start_q_reg, arm_reg;
  logic       dec_reg, dec_next;
  logic       auth_reg, auth_next;
  logic       ad_last_reg, ad_last_next;
  logic       word_cnt_reg, word_cnt_next;
  logic [3:0] round_reg, round_next;
  logic [1:0] tag_cnt_reg, tag_cnt_next;
  logic       key_pend_reg, key_pend_next;
  logic       dsep_pend_reg, dsep_pend_next;

  logic [1:0] word_type;
  logic       word_last, word_acc, start_edge, pause, perm_state, round_step, ad_to_txt, tag_step;
  logic       unused_bits;

  assign unused_bits = ^{mode_i[3:1], bdi_type_i[2]};
  assign word_type   = bdi_type_i[1:0];
  assign word_last   = bdi_type_i[3];
  assign word_acc    = bdi_valid_i & bdi_ready_o;
  // arm_reg masks the first cycle after reset so a start_i already high is not taken as an edge
  assign start_edge  = arm_reg & start_i & ~start_q_reg;
  // a pending key/dsep strobe occupies a cycle of its own: no rounds, no handshakes
  assign pause       = key_pend_reg | dsep_pend_reg;
  assign perm_state  = (state_reg == S_INIT_PERM) || (state_reg == S_AD_PERM) ||
                       (state_reg == S_TXT_PERM)  || (state_reg == S_FIN_PERM);
  assign round_step  = perm_state & ~pause;
  assign ad_to_txt   = (state_reg == S_AD_ABS) && !pause && bdi_valid_i &&
                       (word_type == T_TXT) && !word_cnt_reg;
  assign tag_step    = (state_reg == S_TAG) && !pause &&
                       (dec_reg ? (word_acc && word_type == T_TAG) : 1'b1);

  // state and control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= S_IDLE;
      start_q_reg   <= 1'b0;
      arm_reg       <= 1'b0;
      dec_reg       <= 1'b0;
      auth_reg      <= 1'b0;
      ad_last_reg   <= 1'b0;
      word_cnt_reg  <= 1'b0;
      round_reg     <= 4'd0;
      tag_cnt_reg   <= 2'd0;
      key_pend_reg  <= 1'b0;
      dsep_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      start_q_reg   <= start_i;
      arm_reg       <= 1'b1;
      dec_reg       <= dec_next;
      auth_reg      <= auth_next;
      ad_last_reg   <= ad_last_next;
      word_cnt_reg  <= word_cnt_next;
      round_reg     <= round_next;
      tag_cnt_reg   <= tag_cnt_next;
      key_pend_reg  <= key_pend_next;
      dsep_pend_reg <= dsep_pend_next;
    end
  end

  // next-state and counter update
  always_comb begin
    state_next     = state_reg;
    dec_next       = dec_reg;
    auth_next      = auth_reg;
    ad_last_next   = ad_last_reg;
    word_cnt_next  = word_cnt_reg;
    round_next     = round_reg;
    tag_cnt_next   = tag_cnt_reg;
    key_pend_next  = 1'b0;
    dsep_pend_next = 1'b0;
    unique case (state_reg)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_next    = S_INIT;
          dec_next      = mode_i[0];
          auth_next     = 1'b0;
          ad_last_next  = 1'b0;
          word_cnt_next = 1'b0;
          tag_cnt_next  = 2'd0;
        end
      end
      S_INIT: begin
        state_next = S_INIT_PERM;
        round_next = RND_A0;
      end
      S_INIT_PERM, S_AD_PERM, S_TXT_PERM, S_FIN_PERM: begin
        if (round_step) begin
          if (round_reg != RND_LAST) begin
            round_next = round_reg + 4'd1;
          end else begin
            unique case (state_reg)
              S_INIT_PERM: begin
                state_next    = S_AD_ABS;
                key_pend_next = 1'b1;
              end
              S_AD_PERM: begin
                state_next     = ad_last_reg ? S_TXT_ABS : S_AD_ABS;
                dsep_pend_next = ad_last_reg;
              end
              S_TXT_PERM: state_next = S_TXT_ABS;
              default: begin
                state_next    = S_TAG;
                key_pend_next = 1'b1;
                auth_next     = 1'b1;
                tag_cnt_next  = 2'd0;
              end
            endcase
          end
        end
      end
      S_AD_ABS: begin
        if (ad_to_txt) begin
          state_next = S_TXT_ABS;
        end else if (word_acc && word_type == T_AD) begin
          if (word_last || word_cnt_reg) begin
            state_next    = S_AD_PERM;
            word_cnt_next = 1'b0;
            round_next    = RND_B0;
            ad_last_next  = word_last;
          end else begin
            word_cnt_next = 1'b1;
          end
        end
      end
      S_TXT_ABS: begin
        if (word_acc && word_type == T_TXT) begin
          if (word_last) begin
            state_next    = S_FIN_PERM;
            key_pend_next = 1'b1;
            word_cnt_next = 1'b0;
            round_next    = RND_A0;
          end else if (word_cnt_reg) begin
            state_next    = S_TXT_PERM;
            word_cnt_next = 1'b0;
            round_next    = RND_B0;
          end else begin
            word_cnt_next = 1'b1;
          end
        end
      end
      S_TAG: begin
        if (tag_step) begin
          if (dec_reg) auth_next = auth_reg & tag_eq_i;
          if (tag_cnt_reg == 2'd3) state_next = S_DONE;
          else tag_cnt_next = tag_cnt_reg + 2'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // output decode
  always_comb begin
    bdi_ready_o = 1'b0;
    load_init_o = 1'b0;
    absorb_o    = 1'b0;
    round_en_o  = 1'b0;
    round_idx_o = 4'd0;
    tag_out_o   = 1'b0;
    tag_idx_o   = 2'd0;
    busy_o      = (state_reg != S_IDLE) && (state_reg != S_DONE);
    done_o      = (state_reg == S_DONE);
    auth_o      = (state_reg == S_DONE) && auth_reg && dec_reg;
    key_xor_o   = key_pend_reg;
    dsep_o      = dsep_pend_reg | ad_to_txt;
    unique case (state_reg)
      S_INIT: load_init_o = 1'b1;
      S_INIT_PERM, S_AD_PERM, S_TXT_PERM, S_FIN_PERM: begin
        round_en_o  = round_step;
        round_idx_o = round_step ? round_reg : 4'd0;
      end
      S_AD_ABS: begin
        if (!pause) begin
          bdi_ready_o = !ad_to_txt;
          absorb_o    = bdi_valid_i && (word_type == T_AD);
        end
      end
      S_TXT_ABS: begin
        if (!pause) begin
          bdi_ready_o = 1'b1;
          absorb_o    = bdi_valid_i && (word_type == T_TXT);
        end
      end
      S_TAG: begin
        if (!pause) begin
          bdi_ready_o = dec_reg;
          tag_out_o   = !dec_reg;
          tag_idx_o   = tag_cnt_reg;
        end
      end
      default: ;
    endcase
    absorb_last_o = absorb_o & word_last;
  end

endmodule

// File: tb/tb_ascon_ctrl.sv
// tb_ascon_ctrl: table-driven and randomized checks of the Ascon control FSM
// against a transaction-level model of the expected strobe/round sequence.
module tb_ascon_ctrl;

  localparam int RA = 12;
  localparam int RB = 6;

  logic       clk_i = 1'b0;
  logic       rst_ni, start_i, bdi_valid_i, tag_eq_i;
  logic [3:0] mode_i, bdi_type_i;
  logic       bdi_ready_o, load_init_o, absorb_o, absorb_last_o, key_xor_o, dsep_o;
  logic       round_en_o, tag_out_o, busy_o, done_o, auth_o;
  logic [3:0] round_idx_o;
  logic [1:0] tag_idx_o;

  ascon_ctrl #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .bdi_valid_i(bdi_valid_i), .bdi_type_i(bdi_type_i), .bdi_ready_o(bdi_ready_o),
    .load_init_o(load_init_o), .absorb_o(absorb_o), .absorb_last_o(absorb_last_o),
    .key_xor_o(key_xor_o), .dsep_o(dsep_o), .round_en_o(round_en_o),
    .round_idx_o(round_idx_o), .tag_out_o(tag_out_o), .tag_idx_o(tag_idx_o),
    .tag_eq_i(tag_eq_i), .busy_o(busy_o), .done_o(done_o), .auth_o(auth_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit dec;
    int n_ad;
    int n_txt;
    int bad_tag;
    int junk;
    int exp_rounds;
    bit exp_auth;
  } vec_t;

  typedef struct {
    logic [3:0] typ;
    bit         eq;
  } word_t;

  word_t wq[$];
  int    exp_r[$];
  int    total = 0;
  int    bad = 0;
  int    op_no = 0;
  vec_t  vecs[7];

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL op%0d %s: got %0d expected %0d", op_no, nm, act, req);
    end
  endtask

  function automatic int outs();
    return int'({bdi_ready_o, load_init_o, absorb_o, absorb_last_o, key_xor_o, dsep_o,
                 round_en_o, round_idx_o, tag_out_o, tag_idx_o, busy_o, done_o, auth_o});
  endfunction

  // input word stream: optional junk tag-type words, AD, text, then tag words on decrypt
  task automatic build_stream(input vec_t v);
    wq.delete();
    for (int i = 0; i < v.junk; i++) wq.push_back('{4'b0011, 1'b1});
    for (int i = 0; i < v.n_ad; i++) wq.push_back('{(i == v.n_ad - 1) ? 4'b1001 : 4'b0001, 1'b1});
    for (int i = 0; i < v.n_txt; i++) wq.push_back('{(i == v.n_txt - 1) ? 4'b1010 : 4'b0010, 1'b1});
    if (v.dec)
      for (int i = 0; i < 4; i++) wq.push_back('{(i == 3) ? 4'b1011 : 4'b0011, (i != v.bad_tag)});
  endtask

  // expected round-index stream: init perm, one short perm per AD block,
  // one per full non-final text block, final perm
  task automatic build_exp(input vec_t v);
    int nperm;
    exp_r.delete();
    nperm = (v.n_ad + 1) / 2 + (v.n_txt - 1) / 2;
    for (int r = 12 - RA; r < 12; r++) exp_r.push_back(r);
    for (int p = 0; p < nperm; p++)
      for (int r = 12 - RB; r < 12; r++) exp_r.push_back(r);
    for (int r = 12 - RA; r < 12; r++) exp_r.push_back(r);
  endtask

  task automatic run_op(input vec_t v, input bit abort_fin);
    int obs_r[$];
    int obs_t[$];
    int n_abs = 0, n_last = 0, n_dsep = 0, n_key = 0, n_init = 0, n_conf = 0, n_idle = 0;
    int txt_seen = 0, dsep_cyc = -1, txt_cyc = -1, mm = 0;
    bit finished = 0;
    op_no++;
    build_stream(v);
    build_exp(v);
    @(posedge clk_i); #1;
    start_i = 1'b0; bdi_valid_i = 1'b0;
    @(posedge clk_i); #1;
    mode_i = {3'($urandom), v.dec};
    start_i = 1'b1;
    @(posedge clk_i);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      #1;
      mode_i  = 4'($urandom);
      start_i = (txt_seen == 0) ? 1'($urandom) : 1'b1;
      if (wq.size() > 0 && ($urandom % 4) != 0) begin
        bdi_valid_i = 1'b1; bdi_type_i = wq[0].typ; tag_eq_i = wq[0].eq;
      end else begin
        bdi_valid_i = 1'b0; bdi_type_i = 4'($urandom); tag_eq_i = 1'($urandom);
      end
      @(negedge clk_i);
      if (round_en_o) begin
        obs_r.push_back(int'(round_idx_o));
        if (load_init_o | key_xor_o | dsep_o | absorb_o) n_conf++;
      end
      if (load_init_o) n_init++;
      if (key_xor_o) n_key++;
      if (dsep_o) begin n_dsep++; dsep_cyc = cyc; end
      if (absorb_o) begin
        n_abs++;
        if (absorb_last_o) n_last++;
        if (bdi_type_i[1:0] == 2'd2) begin
          txt_seen++;
          if (txt_cyc < 0) txt_cyc = cyc;
        end
      end
      if (tag_out_o) obs_t.push_back(int'(tag_idx_o));
      if (bdi_valid_i && bdi_ready_o) begin
        if (v.dec && bdi_type_i[1:0] == 2'd3 && txt_seen == v.n_txt) obs_t.push_back(int'(tag_idx_o));
        void'(wq.pop_front());
      end
      if (!busy_o && !done_o) n_idle++;
      if (done_o) begin finished = 1; break; end
      if (abort_fin && n_key == 2 && obs_r.size() >= exp_r.size() - 8) begin
        rst_ni = 1'b0;
        #1;
        check("rst_outputs_zero", outs(), 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("post_reset_idle", outs(), 0);
        $display("op%0d reset during FIN_PERM after %0d rounds", op_no, obs_r.size());
        return;
      end
      @(posedge clk_i);
    end
    bdi_valid_i = 1'b0;
    check("finished", finished, 1);
    check("load_init_cnt", n_init, 1);
    check("key_xor_cnt", n_key, 3);
    check("dsep_cnt", n_dsep, 1);
    check("dsep_before_text", (dsep_cyc >= 0 && dsep_cyc < txt_cyc) ? 1 : 0, 1);
    check("absorb_cnt", n_abs, v.n_ad + v.n_txt);
    check("absorb_last_cnt", n_last, (v.n_ad > 0 ? 1 : 0) + 1);
    check("strobe_round_overlap", n_conf, 0);
    check("busy_gaps", n_idle, 0);
    check("round_cycles", obs_r.size(), v.exp_rounds);
    mm = (obs_r.size() > exp_r.size()) ? obs_r.size() - exp_r.size() : exp_r.size() - obs_r.size();
    for (int i = 0; i < obs_r.size() && i < exp_r.size(); i++) if (obs_r[i] != exp_r[i]) mm++;
    check("round_idx_seq", mm, 0);
    mm = (obs_t.size() > 4) ? obs_t.size() - 4 : 4 - obs_t.size();
    for (int i = 0; i < obs_t.size() && i < 4; i++) if (obs_t[i] != i) mm++;
    check("tag_idx_seq", mm, 0);
    check("auth", auth_o, v.exp_auth);
    check("busy_at_done", busy_o, 0);
    check("words_left", wq.size(), 0);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    check("done_held", done_o, 1);
    check("no_restart_busy", busy_o, 0);
    check("auth_held", auth_o, v.exp_auth);
    $display("op%0d dec=%0d ad=%0d txt=%0d junk=%0d rounds=%0d auth=%0d done=%0d",
             op_no, v.dec, v.n_ad, v.n_txt, v.junk, obs_r.size(), auth_o, done_o);
  endtask

  initial begin
    vec_t v;
    rst_ni = 1'b0; start_i = 1'b1; mode_i = 4'd0;
    bdi_valid_i = 1'b0; bdi_type_i = 4'd0; tag_eq_i = 1'b0;
    vecs[0] = '{1'b0, 2, 2, -1, 0, 30, 1'b0};
    vecs[1] = '{1'b1, 0, 1, -1, 0, 24, 1'b1};
    vecs[2] = '{1'b1, 0, 1,  2, 0, 24, 1'b0};
    vecs[3] = '{1'b0, 3, 3, -1, 1, 42, 1'b0};
    vecs[4] = '{1'b1, 1, 4, -1, 0, 36, 1'b1};
    vecs[5] = '{1'b1, 4, 2,  0, 1, 36, 1'b0};
    vecs[6] = '{1'b0, 0, 5, -1, 1, 36, 1'b0};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", outs(), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("start_high_at_release", busy_o, 0);
    $display("reset released with start high, busy=%0d", busy_o);

    foreach (vecs[i]) run_op(vecs[i], 1'b0);

    run_op('{1'b0, 1, 1, -1, 0, 30, 1'b0}, 1'b1);
    run_op('{1'b1, 2, 1, -1, 0, 30, 1'b1}, 1'b0);

    for (int k = 0; k < 8; k++) begin
      v.dec        = 1'($urandom);
      v.n_ad       = $urandom % 5;
      v.n_txt      = 1 + $urandom % 5;
      v.bad_tag    = (v.dec && ($urandom % 2)) ? int'($urandom % 4) : -1;
      v.junk       = $urandom % 2;
      v.exp_rounds = 2 * RA + RB * ((v.n_ad + 1) / 2 + (v.n_txt - 1) / 2);
      v.exp_auth   = v.dec && (v.bad_tag < 0);
      run_op(v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
